fb_bit_loader: RTL and testbench

Upstream feeder for the 1-bit video framebuffer. It accepts a serial pixel-bit stream over a valid/ready handshake, buffers it in a small FIFO, and writes it raster-order into framebuffer RAM only while the VGA controller reports blanking (display_active low). This keeps RAM writes from colliding with display reads. One frame is FB_W×FB_H bits, started by a frame_start pulse, typically the edge-detected vs.

---
 rtl/fb_pkg.sv | 16 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/fb_bit_loader.sv | 164 ++++++++++++++++
 tb/tb_fb_bit_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and loader state type for the 1-bit framebuffer path.
package fb_pkg;

  localparam int unsigned FB_W      = 80;
  localparam int unsigned FB_H      = 60;
  localparam int unsigned FB_X_W    = $clog2(FB_W);
  localparam int unsigned FB_Y_W    = $clog2(FB_H);
  localparam int unsigned FB_PIXELS = FB_W * FB_H;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; a pop loads rdata_o on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/fb_bit_loader.sv
// Buffers a serial pixel-bit stream and writes it raster-order into framebuffer RAM,
// only issuing pops while the VGA controller is blanking.
module fb_bit_loader #(
  parameter int unsigned FB_W       = fb_pkg::FB_W,
  parameter int unsigned FB_H       = fb_pkg::FB_H,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    display_active,
  input  logic                    frame_start,
  input  logic                    s_valid,
  input  logic                    s_data,
  output logic                    s_ready,
  output logic                    wr_en,
  output logic [$clog2(FB_W)-1:0] wr_x,
  output logic [$clog2(FB_H)-1:0] wr_y,
  output logic                    wr_data,
  output logic                    busy,
  output logic                    frame_done
);

  import fb_pkg::*;

  localparam int unsigned XW = $clog2(FB_W);
  localparam int unsigned YW = $clog2(FB_H);
  localparam logic [XW-1:0] X_LAST = XW'(FB_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_H - 1);

  ld_state_e     state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic          s1_vld_q;
  logic          s1_last_q;
  logic          wr_en_q;
  logic          wr_last_q;
  logic [XW-1:0] wr_x_q;
  logic [YW-1:0] wr_y_q;
  logic          wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic          rdy_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [0:0]    fifo_rdata;
  logic          at_last;
  logic          restart;
  logic          advance;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid && s_ready),
    .wdata_i (s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_ready = rdy_q && !fifo_full;
  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign restart = frame_start && (state_q != LD_DONE);
  // busy_q doubles as "pixels still to pop in this frame".
  assign fifo_pop = (state_q == LD_LOAD) && busy_q && !fifo_empty &&
                    !display_active && !frame_start;
  // A popped bit waits in stage 1 while the display is active, so at most the
  // write already registered on the rising edge lands in the visible area.
  assign advance  = s1_vld_q && !display_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LD_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      done_q    <= 1'b0;

      if (restart) begin
        s1_vld_q <= 1'b0;
      end else if (advance) begin
        wr_en_q   <= 1'b1;
        wr_x_q    <= s1_x_q;
        wr_y_q    <= s1_y_q;
        wr_data_q <= fifo_rdata[0];
        wr_last_q <= s1_last_q;
        s1_vld_q  <= 1'b0;
      end

      if (fifo_pop) begin
        s1_vld_q  <= 1'b1;
        s1_x_q    <= x_q;
        s1_y_q    <= y_q;
        s1_last_q <= at_last;
        if (at_last) begin
          busy_q <= 1'b0;
        end
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      case (state_q)
        LD_IDLE: begin
          if (frame_start) begin
            state_q <= LD_LOAD;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (frame_start) begin
            x_q    <= '0;
            y_q    <= '0;
            busy_q <= 1'b1;
          end else if (wr_en_q && wr_last_q) begin
            state_q <= LD_DONE;
            done_q  <= 1'b1;
          end
        end
        LD_DONE: begin
          state_q <= LD_IDLE;
        end
        default: begin
          state_q <= LD_IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fb_bit_loader.sv
// Randomized bench for fb_bit_loader: accepted bits feed a queue scoreboard, and each
// write is expected at raster position k with the oldest outstanding bit.
module tb_fb_bit_loader;

  import fb_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                display_active;
  logic                frame_start;
  logic                s_valid;
  logic                s_data;
  logic                s_ready;
  logic                wr_en;
  logic [FB_X_W-1:0]   wr_x;
  logic [FB_Y_W-1:0]   wr_y;
  logic                wr_data;
  logic                busy;
  logic                frame_done;

  always #5 clk = ~clk;

  fb_bit_loader #(
    .FB_W       (FB_W),
    .FB_H       (FB_H),
    .FIFO_DEPTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .display_active (display_active),
    .frame_start    (frame_start),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .wr_en          (wr_en),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_data        (wr_data),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          q[$];
  int unsigned k = 0;
  int unsigned nxt_idx = 0;
  int unsigned wr_seen = 0;
  int unsigned ones_seen = 0;
  int unsigned viol = 0;
  bit          exp_done_cur = 1'b0;
  bit          exp_done_nxt = 1'b0;
  bit          da_prev = 1'b0;
  bit          wr_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          b;
    int unsigned e;
    if (s_valid && s_ready) begin
      q.push_back(s_data);
      nxt_idx++;
    end
    if (frame_start && !exp_done_cur) k = 0;
    @(posedge clk);
    @(negedge clk);
    // A write may start in the first visible cycle only (the pipeline drain).
    if (wr_prev && display_active && da_prev) viol++;
    da_prev = display_active;
    wr_prev = wr_en;
    exp_done_cur = exp_done_nxt;
    exp_done_nxt = 1'b0;
    chk("frame_done", frame_done, exp_done_cur);
    if (wr_en) begin
      wr_seen++;
      if (wr_data) ones_seen++;
      if (q.size() == 0 || k >= FB_PIXELS) begin
        chk("wr_unexpected", wr_en, 1'b0);
      end else begin
        b = q.pop_front();
        e = ((k / FB_W) << (FB_X_W + 1)) | ((k % FB_W) << 1) | b;
        chk("wr_yxd", 32'({wr_y, wr_x, wr_data}), e);
        k++;
        if (k == FB_PIXELS) exp_done_nxt = 1'b1;
      end
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int unsigned w0;
    int unsigned n;
    int unsigned ph;

    rst = 1'b1;
    display_active = 1'b0;
    frame_start = 1'b0;
    s_valid = 1'b0;
    s_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_x", wr_x, 0);
    chk("rst_wr_y", wr_y, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Backpressure with the FSM idle
    s_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      s_data = 1'($urandom);
      tick();
    end
    chk("bp_accepts", q.size(), 16);
    chk("bp_ready_low", s_ready, 0);
    chk("bp_idle_busy", busy, 0);
    w0 = wr_seen;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("bp_ready_at_start", s_ready, 0);
    chk("busy_after_start", busy, 1);
    tick();
    chk("bp_ready_after_pop", s_ready, 1);
    n = 0;
    while (q.size() + wr_seen - w0 < 20 && n < 100) begin
      s_data = 1'($urandom);
      tick();
      n++;
    end
    s_valid = 1'b0;
    drain(200);
    chk("bp_writes", wr_seen - w0, 20);

    // Advance the cursor to (37,5), then restart with buffered data
    n = 0;
    while (k + q.size() < 5 * FB_W + 37 && n < 3000) begin
      s_valid = 1'b1;
      s_data = 1'($urandom);
      tick();
      n++;
    end
    s_valid = 1'b0;
    drain(200);
    display_active = 1'b1;
    s_valid = 1'b1;
    n = 0;
    while (q.size() < 10 && n < 50) begin
      s_data = 1'($urandom);
      tick();
      n++;
    end
    s_valid = 1'b0;
    w0 = wr_seen;
    repeat (3) tick();
    chk("active_hold_writes", wr_seen - w0, 0);
    frame_start = 1'b1;
    display_active = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("restart_no_wr", wr_en, 0);
    chk("restart_busy", busy, 1);
    w0 = wr_seen;
    nxt_idx = q.size();

    // Full frame with display_active cycling 5 low / 10 high and random input gaps
    ph = 0;
    n = 0;
    while (!exp_done_cur && n < 40000) begin
      display_active = (ph % 15) >= 5;
      s_valid = ($urandom_range(3) != 0) && (nxt_idx < FB_PIXELS);
      s_data = 1'($urandom);
      tick();
      ph++;
      n++;
    end
    chk("frame2_done_seen", exp_done_cur, 1);
    chk("gating_viol", viol, 0);
    chk("frame2_writes", wr_seen - w0, FB_PIXELS);
    chk("busy_in_done", busy, 0);

    // frame_start in the DONE cycle is ignored; bits pre-buffer for the next frame
    display_active = 1'b0;
    nxt_idx = 0;
    frame_start = 1'b1;
    s_valid = 1'b1;
    s_data = (nxt_idx == 2 + 2 * FB_W);
    tick();
    frame_start = 1'b0;
    chk("done_fs_ignored_busy", busy, 0);
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) begin
      s_data = (nxt_idx == 2 + 2 * FB_W);
      tick();
    end
    chk("idle_no_writes", wr_seen - w0, 0);
    chk("idle_busy", busy, 0);

    // Continuous frame in blanking, single set pixel at (2,2)
    frame_start = 1'b1;
    s_data = (nxt_idx == 2 + 2 * FB_W);
    tick();
    frame_start = 1'b0;
    chk("frame3_busy", busy, 1);
    w0 = wr_seen;
    ones_seen = 0;
    n = 0;
    while (!exp_done_cur && n < 10000) begin
      s_valid = (nxt_idx < FB_PIXELS);
      s_data = (nxt_idx == 2 + 2 * FB_W);
      tick();
      n++;
    end
    s_valid = 1'b0;
    chk("frame3_done_seen", exp_done_cur, 1);
    chk("frame3_writes", wr_seen - w0, FB_PIXELS);
    chk("frame3_ones", ones_seen, 1);
    repeat (3) tick();
    chk("final_idle_busy", busy, 0);
    chk("final_wr_en", wr_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
